// File: rtl/prog_loader.sv
// Serial program loader: parses an 0xA5-framed byte stream into 28-bit
// instruction words, writes them to instruction memory and verifies an XOR checksum.
package affine;
  localparam int A      = 8;
  localparam int W_INST = 28;
endpackage

module prog_loader #(
  parameter int A      = affine::A,
  parameter int W_INST = affine::W_INST
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              we_o,
  output logic [A-1:0]      waddr_o,
  output logic [W_INST-1:0] wdata_o,
  output logic              core_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t state, state_nx;

  logic              accept;
  logic [15:0]       n_words;
  logic [15:0]       count_n;
  logic [16:0]       n_max;
  logic [A:0]        addr_q;
  logic [1:0]        byte_q;
  logic [7:0]        csum_q;
  logic [23:0]       shift_q;
  logic              last_word;
  logic              err_q;
  logic              core_rst_q;
  logic              vld_p1;
  logic [A-1:0]      waddr_p1;
  logic [W_INST-1:0] wdata_p1;

  assign rx_ready_o = ~rst_i;
  assign accept     = rx_valid_i & rx_ready_o;
  assign count_n    = {n_words[15:8], rx_data_i};
  assign n_max      = 17'(1) << A;
  // Address counter is one bit wider than A so a full 2^A-word image is reachable.
  assign last_word  = (17'(addr_q) + 17'd1) == {1'b0, n_words};

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept && rx_data_i == 8'hA5) state_nx = S_CNT_HI;
      end
      S_CNT_HI: begin
        if (accept) state_nx = S_CNT_LO;
      end
      S_CNT_LO: begin
        if (accept) begin
          if (count_n == 16'd0)              state_nx = S_CSUM;
          else if ({1'b0, count_n} > n_max)  state_nx = S_ERR;
          else                               state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          if (byte_q == 2'd0 && rx_data_i[7:4] != 4'd0) state_nx = S_ERR;
          else if (byte_q == 2'd3 && last_word)         state_nx = S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) state_nx = (rx_data_i == csum_q) ? S_DONE : S_ERR;
      end
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Byte capture / word assembly stage; write strobe and data land in _p1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n_words    <= '0;
      addr_q     <= '0;
      byte_q     <= '0;
      csum_q     <= '0;
      shift_q    <= '0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b1;
      vld_p1     <= 1'b0;
      waddr_p1   <= '0;
      wdata_p1   <= '0;
    end else begin
      vld_p1 <= 1'b0;
      if (accept) begin
        case (state)
          S_IDLE: begin
            if (rx_data_i == 8'hA5) begin
              err_q      <= 1'b0;
              core_rst_q <= 1'b1;
              addr_q     <= '0;
              byte_q     <= '0;
              csum_q     <= '0;
            end
          end
          S_CNT_HI: n_words[15:8] <= rx_data_i;
          S_CNT_LO: n_words[7:0]  <= rx_data_i;
          S_DATA: begin
            csum_q  <= csum_q ^ rx_data_i;
            byte_q  <= byte_q + 2'd1;
            shift_q <= {shift_q[15:0], rx_data_i};
            if (byte_q == 2'd3) begin
              vld_p1   <= 1'b1;
              waddr_p1 <= addr_q[A-1:0];
              wdata_p1 <= W_INST'({shift_q, rx_data_i});
              addr_q   <= addr_q + {{A{1'b0}}, 1'b1};
            end
          end
          default: ;
        endcase
      end
      if (state != S_ERR && state_nx == S_ERR) err_q <= 1'b1;
      if (state == S_CSUM && state_nx == S_DONE) core_rst_q <= 1'b0;
    end
  end

  assign we_o       = vld_p1;
  assign waddr_o    = waddr_p1;
  assign wdata_o    = wdata_p1;
  assign err_o      = err_q;
  assign core_rst_o = core_rst_q;
  assign done_o     = (state == S_DONE);
  assign busy_o     = (state == S_CNT_HI) || (state == S_CNT_LO) ||
                      (state == S_DATA)   || (state == S_CSUM);

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a frame-level parser model predicts per-byte events,
// a negedge monitor checks every output each cycle, plus literal end-of-frame checks.
module tb_prog_loader;
  localparam int AW = 8;
  localparam int WI = 28;

  logic          clk;
  logic          rst_i;
  logic [7:0]    rx_data_i;
  logic          rx_valid_i;
  logic          rx_ready_o;
  logic          we_o;
  logic [AW-1:0] waddr_o;
  logic [WI-1:0] wdata_o;
  logic          core_rst_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  prog_loader #(.A(AW), .W_INST(WI)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .we_o       (we_o),
    .waddr_o    (waddr_o),
    .wdata_o    (wdata_o),
    .core_rst_o (core_rst_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model output: per byte index, what the loader must do.
  bit            is_wr [64];
  logic [AW-1:0] w_addr[64];
  logic [WI-1:0] w_data[64];
  int            end_idx;
  int            outcome;   // 0 none, 1 done, 2 error
  bit            m_act;

  // Expected output state, advanced by the driver after each accepted byte.
  bit            chk_en = 1'b0;
  logic          exp_we, exp_done, m_err, m_core_rst, m_busy;
  logic [AW-1:0] m_addr;
  logic [WI-1:0] m_data;

  logic [AW+WI-1:0] dut_w[$];
  int               done_cnt;

  task automatic build_model(input logic [7:0] fr[$]);
    int n;
    logic [7:0] x;
    for (int i = 0; i < 64; i++) is_wr[i] = 1'b0;
    end_idx = -1;
    outcome = 0;
    m_act   = (fr.size() >= 1) && (fr[0] == 8'hA5);
    if (!m_act || fr.size() < 3) return;
    n = {fr[1], fr[2]};
    if (n > (1 << AW)) begin
      end_idx = 2;
      outcome = 2;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      int b;
      b = 3 + 4 * k;
      if (b >= fr.size()) return;
      if (fr[b][7:4] != 4'h0) begin
        end_idx = b;
        outcome = 2;
        return;
      end
      if (b + 3 >= fr.size()) return;
      x = x ^ fr[b] ^ fr[b+1] ^ fr[b+2] ^ fr[b+3];
      is_wr[b+3]  = 1'b1;
      w_addr[b+3] = AW'(k);
      w_data[b+3] = {fr[b][3:0], fr[b+1], fr[b+2], fr[b+3]};
    end
    if (3 + 4 * n < fr.size()) begin
      end_idx = 3 + 4 * n;
      outcome = (fr[end_idx] == x) ? 1 : 2;
    end
  endtask

  task automatic model_byte(input int i);
    if (!m_act) return;
    if (end_idx >= 0 && i > end_idx) return;
    if (i == 0) begin
      m_err      = 1'b0;
      m_core_rst = 1'b1;
      m_busy     = 1'b1;
    end
    if (is_wr[i]) begin
      exp_we = 1'b1;
      m_addr = w_addr[i];
      m_data = w_data[i];
    end
    if (i == end_idx) begin
      m_busy = 1'b0;
      if (outcome == 1) begin
        exp_done   = 1'b1;
        m_core_rst = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic send(input logic [7:0] fr[$], input int nsend, input int gap);
    build_model(fr);
    dut_w.delete();
    done_cnt = 0;
    for (int i = 0; i < nsend; i++) begin
      rx_valid_i = 1'b1;
      rx_data_i  = fr[i];
      @(posedge clk); #1;
      model_byte(i);
      if (gap > 0) begin
        rx_valid_i = 1'b0;
        rx_data_i  = 8'hA5;
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    rx_valid_i = 1'b0;
    rx_data_i  = 8'hA5;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk); #1;
    m_err      = 1'b0;
    m_core_rst = 1'b1;
    m_busy     = 1'b0;
    m_addr     = '0;
    m_data     = '0;
    exp_we     = 1'b0;
    exp_done   = 1'b0;
    m_act      = 1'b0;
    rst_i      = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("we_o",       we_o,       exp_we);
      chk("done_o",     done_o,     exp_done);
      chk("err_o",      err_o,      m_err);
      chk("core_rst_o", core_rst_o, m_core_rst);
      chk("busy_o",     busy_o,     m_busy);
      chk("waddr_o",    waddr_o,    m_addr);
      chk("wdata_o",    wdata_o,    m_data);
      chk("rx_ready_o", rx_ready_o, !rst_i);
      if (we_o === 1'b1) dut_w.push_back({waddr_o, wdata_o});
      if (done_o === 1'b1) done_cnt++;
      exp_we   = 1'b0;
      exp_done = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] f_ok[$], f_bad[$], f_nib[$], f_zero[$], f_big[$], f_tail[$];
    f_ok   = '{8'hA5, 8'h00, 8'h02, 8'h06, 8'h40, 8'h14, 8'hEC,
               8'h0C, 8'h00, 8'h40, 8'h60, 8'h92};
    f_bad  = '{8'hA5, 8'h00, 8'h02, 8'h06, 8'h40, 8'h14, 8'hEC,
               8'h0C, 8'h00, 8'h40, 8'h60, 8'h93};
    f_nib  = '{8'hA5, 8'h00, 8'h01, 8'h16, 8'h00, 8'h00, 8'h00, 8'h16};
    f_zero = '{8'hA5, 8'h00, 8'h00, 8'h00};
    f_big  = '{8'hA5, 8'h01, 8'h01};
    f_tail = '{8'h40, 8'h60};

    rst_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00;
    exp_we = 1'b0; exp_done = 1'b0; m_err = 1'b0; m_core_rst = 1'b1;
    m_busy = 1'b0; m_addr = '0; m_data = '0; m_act = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Pin the model against hand-computed values for the reference stream.
    build_model(f_ok);
    chk("model_w0", w_data[6], 28'h64014EC);
    chk("model_w1", w_data[10], 28'hC004060);
    chk("model_outcome", outcome, 1);

    send(f_ok, f_ok.size(), 0);
    chk("ok_nwr", dut_w.size(), 2);
    if (dut_w.size() == 2) begin
      chk("ok_w0", dut_w[0], {8'd0, 28'h64014EC});
      chk("ok_w1", dut_w[1], {8'd1, 28'hC004060});
    end
    chk("ok_done", done_cnt, 1);
    chk("ok_err", err_o, 1'b0);
    chk("ok_core_rst", core_rst_o, 1'b0);

    send(f_bad, f_bad.size(), 0);
    chk("bad_nwr", dut_w.size(), 2);
    chk("bad_done", done_cnt, 0);
    chk("bad_err", err_o, 1'b1);
    chk("bad_core_rst", core_rst_o, 1'b1);

    send(f_nib, f_nib.size(), 0);
    chk("nib_nwr", dut_w.size(), 0);
    chk("nib_err", err_o, 1'b1);
    send(f_ok, f_ok.size(), 0);
    chk("nib_recover_err", err_o, 1'b0);
    chk("nib_recover_done", done_cnt, 1);

    send(f_zero, f_zero.size(), 0);
    chk("zero_nwr", dut_w.size(), 0);
    chk("zero_done", done_cnt, 1);
    chk("zero_core_rst", core_rst_o, 1'b0);

    send(f_big, f_big.size(), 0);
    chk("big_nwr", dut_w.size(), 0);
    chk("big_err", err_o, 1'b1);
    chk("big_busy", busy_o, 1'b0);

    send(f_ok, f_ok.size(), 3);
    chk("gap_nwr", dut_w.size(), 2);
    if (dut_w.size() == 2) begin
      chk("gap_w0", dut_w[0], {8'd0, 28'h64014EC});
      chk("gap_w1", dut_w[1], {8'd1, 28'hC004060});
    end
    chk("gap_done", done_cnt, 1);

    send(f_ok, 6, 0);
    do_reset();
    send(f_tail, f_tail.size(), 0);
    chk("rst_nwr", dut_w.size(), 0);
    chk("rst_core_rst", core_rst_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_cnt, 0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter A, default affine::A, instruction-memory address width.
REQ-002 SHALL have parameter W_INST, default affine::W_INST (28), instruction word width.
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx_data_i  input  8  incoming byte.
REQ-006 SHALL have port rx_valid_i  input  1  rx_data_i valid this cycle.
REQ-007 SHALL have port rx_ready_o  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port we_o  output  1  instruction-memory write strobe.
REQ-009 SHALL have port waddr_o  output  A  write address.
REQ-010 SHALL have port wdata_o  output  W_INST  write data.
REQ-011 SHALL have port core_rst_o  output  1  holds the instruction-fetching core in reset.
REQ-012 SHALL have port busy_o  output  1  load in progress.
REQ-013 SHALL have port done_o  output  1  one-cycle pulse on successful load.
REQ-014 SHALL have port err_o  output  1  sticky load-error flag.

Function
REQ-015 SHALL accept a byte only when rx_valid_i and rx_ready_o are both 1; rx_ready_o SHALL be 1 in every state except during a reset cycle.
REQ-016 SHALL implement states IDLE, CNT_HI, CNT_LO, DATA, CSUM, DONE, ERR.
REQ-017 IDLE: accepted byte 0xA5 -> CNT_HI, set core_rst_o=1, clear err_o, address counter=0, checksum=0; any other byte discarded.
REQ-018 CNT_HI/CNT_LO SHALL capture a 16-bit big-endian word count N; after CNT_LO: N=0 -> CSUM; N>2^A -> ERR; otherwise -> DATA.
REQ-019 DATA SHALL assemble each word from 4 bytes, most significant byte first; the upper 4 bits of the first byte SHALL be 0, else -> ERR immediately with no write for that word.
REQ-020 Checksum SHALL be the XOR of all DATA bytes (count bytes excluded).
REQ-021 On acceptance of a word's 4th byte, the next cycle SHALL assert we_o for exactly one cycle with waddr_o=word index and wdata_o=assembled word; address then increments.
REQ-022 After the Nth word's 4th byte -> CSUM; the accepted CSUM byte equal to the running checksum -> DONE, otherwise -> ERR.
REQ-023 DONE SHALL last one cycle: done_o=1, core_rst_o cleared, then -> IDLE.
REQ-024 ERR SHALL set err_o, keep core_rst_o=1, and return to IDLE the next cycle; err_o stays 1 until the next 0xA5 is accepted in IDLE.
REQ-025 busy_o SHALL be 1 in CNT_HI, CNT_LO, DATA and CSUM, and 0 otherwise.
REQ-026 Gaps in rx_valid_i SHALL stall the FSM with no state, counter or output change.
REQ-027 we_o, waddr_o and wdata_o SHALL be registered; waddr_o/wdata_o hold their last values when we_o=0.
REQ-028 Address SHALL never wrap: N<=2^A is enforced by REQ-018.

Reset
REQ-029 rst_i SHALL force IDLE, we_o=0, done_o=0, err_o=0, busy_o=0, rx_ready_o=0, core_rst_o=1, and waddr_o, wdata_o, word count, byte counter and checksum all 0.
REQ-030 Reset mid-load SHALL abandon the load without further writes; a new load SHALL require 0xA5.

Verification
REQ-031 Bytes A5 00 02 06 40 14 EC 0C 00 40 60 92 -> we_o at addr 0 data 0x64014EC, addr 1 data 0xC004060; done_o pulses; core_rst_o falls; err_o=0.
REQ-032 Same stream with checksum 0x93 -> both writes occur; err_o=1, core_rst_o=1, no done_o.
REQ-033 A5 00 01 16 ... -> ERR on byte 0x16, no we_o, err_o=1; a following valid load clears err_o at 0xA5.
REQ-034 A5 00 00 00 -> no writes, done_o pulse; with A=8, A5 01 01 -> ERR immediately after the count.
REQ-035 Stream of REQ-031 with rx_valid_i low for 3 cycles between every byte -> identical writes and identical done_o.
REQ-036 rst_i asserted after the 6th byte of REQ-031, then 0x40 0x60 sent -> no we_o, state IDLE, core_rst_o=1.
